// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the fetch stage; also consumed by the decoder package.
package pkg_instr_fetch;

    localparam int INSTR_W    = 16;
    localparam int MEM_DATA_W = 8;
    // PC width carried in a buffered entry; the fetch stage's ADDR_W must match it.
    localparam int FETCH_PC_W = 16;

    typedef enum logic [0:0] {
        S_HI = 1'b0,
        S_LO = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0]    word;
        logic [FETCH_PC_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Small synchronous FIFO of fetched instructions with a single-cycle flush.
module instr_fetch_fifo
    import pkg_instr_fetch::*;
#(
    parameter int  DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic             do_pop;

    assign do_pop = pop && (count_q != '0);

    // Next pointers, count and storage; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; entries are only read while counted.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

    // Upstream space reservation must make pushing into a full buffer unreachable.
    a_no_push_when_full : assert property (
        @(posedge clk) disable iff (rst)
        !(push && !flush && (count_q == CNT_W'(DEPTH)))
    );

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: reads big-endian 16-bit instructions byte by byte and buffers them for decode.
module instr_fetch
    import pkg_instr_fetch::*;
#(
    parameter int               ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter int               BUF_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [MEM_DATA_W-1:0] mem_rdata,
    output logic                  instr_valid,
    output logic [INSTR_W-1:0]    instr_word,
    output logic [ADDR_W-1:0]     instr_pc,
    input  logic                  dec_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_W-1:0]     redirect_pc
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_t          state_q, state_d;
    logic [ADDR_W-1:0]     fetch_pc_q, fetch_pc_d;
    logic                  pend_hi_q, pend_hi_d;
    logic                  pend_lo_q, pend_lo_d;
    logic [MEM_DATA_W-1:0] hi_byte_q, hi_byte_d;

    logic                  inflight;
    logic                  space_ok;
    logic                  issue_hi;
    logic                  issue_lo;
    logic                  push;
    logic                  pop;
    fetch_entry_t          push_entry;
    fetch_entry_t          head;
    logic [CNT_W-1:0]      buf_count;
    logic                  buf_empty;
    logic                  redirect_pc_lsb_unused;

    assign redirect_pc_lsb_unused = redirect_pc[0];

    // An instruction is in flight from its hi request until its lo byte is pushed.
    assign inflight = pend_hi_q | pend_lo_q;
    assign space_ok = (buf_count + CNT_W'(inflight)) < CNT_W'(BUF_DEPTH);

    // Reset and redirect both suppress requests in the same cycle.
    assign issue_hi = !reset && !redirect_valid && (state_q == S_HI) && space_ok;
    assign issue_lo = !reset && !redirect_valid && (state_q == S_LO);

    assign mem_rd_en = issue_hi | issue_lo;
    assign mem_addr  = (state_q == S_LO) ? fetch_pc_q + ADDR_W'(1) : fetch_pc_q;

    // fetch_pc has already advanced by 2 when the lo byte returns.
    assign push            = pend_lo_q && !redirect_valid;
    assign push_entry.word = {hi_byte_q, mem_rdata};
    assign push_entry.pc   = fetch_pc_q - ADDR_W'(2);
    assign pop             = instr_valid && dec_ready && !redirect_valid;

    // FSM next state, fetch PC and returned-byte tracking.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pend_hi_d  = issue_hi;
        pend_lo_d  = issue_lo;
        hi_byte_d  = pend_hi_q ? mem_rdata : hi_byte_q;
        if (redirect_valid) begin
            state_d    = S_HI;
            fetch_pc_d = {redirect_pc[ADDR_W-1:1], 1'b0};
            pend_hi_d  = 1'b0;
            pend_lo_d  = 1'b0;
        end else begin
            case (state_q)
                S_HI: begin
                    if (issue_hi) begin
                        state_d = S_LO;
                    end
                end
                S_LO: begin
                    state_d    = S_HI;
                    fetch_pc_d = fetch_pc_q + ADDR_W'(2);
                end
                default: state_d = S_HI;
            endcase
        end
    end

    // Fetch control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_HI;
            fetch_pc_q <= RESET_PC;
            pend_hi_q  <= 1'b0;
            pend_lo_q  <= 1'b0;
            hi_byte_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_hi_q  <= pend_hi_d;
            pend_lo_q  <= pend_lo_d;
            hi_byte_q  <= hi_byte_d;
        end
    end

    instr_fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (buf_count),
        .empty     (buf_empty)
    );

    assign instr_valid = !buf_empty;
    assign instr_word  = head.word;
    assign instr_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, backpressure, redirect, PC wrap and mid-fetch reset.
module tb_instr_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset0 = 1'b1;
    logic        mem_rd_en0;
    logic [15:0] mem_addr0;
    logic [7:0]  mem_rdata0 = 8'h00;
    logic        instr_valid0;
    logic [15:0] instr_word0;
    logic [15:0] instr_pc0;
    logic        dec_ready0 = 1'b0;
    logic        redirect_valid0 = 1'b0;
    logic [15:0] redirect_pc0 = 16'h0000;

    logic        reset1 = 1'b1;
    logic        mem_rd_en1;
    logic [15:0] mem_addr1;
    logic [7:0]  mem_rdata1 = 8'h00;
    logic        instr_valid1;
    logic [15:0] instr_word1;
    logic [15:0] instr_pc1;
    logic        dec_ready1 = 1'b1;
    logic        redirect_valid1 = 1'b0;
    logic [15:0] redirect_pc1 = 16'h0000;

    logic [7:0]  mem [0:65535];

    int n_checks = 0;
    int n_pass   = 0;

    instr_fetch #(.ADDR_W(16), .RESET_PC(16'h0000), .BUF_DEPTH(2)) dut0 (
        .clk(clk), .reset(reset0), .mem_rd_en(mem_rd_en0), .mem_addr(mem_addr0),
        .mem_rdata(mem_rdata0), .instr_valid(instr_valid0), .instr_word(instr_word0),
        .instr_pc(instr_pc0), .dec_ready(dec_ready0), .redirect_valid(redirect_valid0),
        .redirect_pc(redirect_pc0)
    );

    instr_fetch #(.ADDR_W(16), .RESET_PC(16'hFFFE), .BUF_DEPTH(2)) dut1 (
        .clk(clk), .reset(reset1), .mem_rd_en(mem_rd_en1), .mem_addr(mem_addr1),
        .mem_rdata(mem_rdata1), .instr_valid(instr_valid1), .instr_word(instr_word1),
        .instr_pc(instr_pc1), .dec_ready(dec_ready1), .redirect_valid(redirect_valid1),
        .redirect_pc(redirect_pc1)
    );

    // Byte-wide synchronous memory: data one cycle after the address.
    always @(posedge clk) begin
        mem_rdata0 <= mem[mem_addr0];
        mem_rdata1 <= mem[mem_addr1];
    end

    task automatic start0(input logic rdy);
        reset0          = 1'b1;
        redirect_valid0 = 1'b0;
        dec_ready0      = rdy;
        repeat (2) @(posedge clk);
        #1 reset0 = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (mem_rd_en0 !== 1'b0) $display("FAIL reset_rd_en0: got %b expected 0", mem_rd_en0);
        else n_pass++;
        n_checks++;
        if (instr_valid0 !== 1'b0) $display("FAIL reset_valid0: got %b expected 0", instr_valid0);
        else n_pass++;
        n_checks++;
        if (mem_rd_en1 !== 1'b0) $display("FAIL reset_rd_en1: got %b expected 0", mem_rd_en1);
        else n_pass++;
    endtask

    task automatic test_stream();
        logic [15:0] words [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        logic        exp_v;
        int          idx;
        start0(1'b1);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            n_checks++;
            if ({mem_rd_en0, mem_addr0} !== {1'b1, 16'(n - 1)})
                $display("FAIL stream_req c%0d: got en=%b addr=%h expected en=1 addr=%h",
                         n, mem_rd_en0, mem_addr0, 16'(n - 1));
            else n_pass++;
            exp_v = (n >= 4) && (n % 2 == 0);
            n_checks++;
            if (instr_valid0 !== exp_v)
                $display("FAIL stream_valid c%0d: got %b expected %b", n, instr_valid0, exp_v);
            else n_pass++;
            if (exp_v) begin
                idx = (n - 4) / 2;
                n_checks++;
                if ({instr_word0, instr_pc0} !== {words[idx], 16'(2 * idx)})
                    $display("FAIL stream_word c%0d: got %h@%h expected %h@%h",
                             n, instr_word0, instr_pc0, words[idx], 16'(2 * idx));
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic exp_en;
        start0(1'b0);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            exp_en = (n <= 4);
            n_checks++;
            if (mem_rd_en0 !== exp_en || (exp_en && mem_addr0 !== 16'(n - 1)))
                $display("FAIL bp_req c%0d: got en=%b addr=%h expected en=%b addr=%h",
                         n, mem_rd_en0, mem_addr0, exp_en, 16'(n - 1));
            else n_pass++;
        end
        n_checks++;
        if ({instr_valid0, instr_word0, instr_pc0} !== {1'b1, 16'h1234, 16'h0000})
            $display("FAIL bp_head: got v=%b %h@%h expected v=1 1234@0000",
                     instr_valid0, instr_word0, instr_pc0);
        else n_pass++;
        dec_ready0 = 1'b1;
        @(posedge clk);
        #1 dec_ready0 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_rd_en0, mem_addr0} !== {1'b1, 16'h0004})
            $display("FAIL bp_resume: got en=%b addr=%h expected en=1 addr=0004", mem_rd_en0, mem_addr0);
        else n_pass++;
        n_checks++;
        if ({instr_valid0, instr_word0, instr_pc0} !== {1'b1, 16'h5678, 16'h0002})
            $display("FAIL bp_next_head: got v=%b %h@%h expected v=1 5678@0002",
                     instr_valid0, instr_word0, instr_pc0);
        else n_pass++;
    endtask

    task automatic test_redirect();
        start0(1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        redirect_valid0 = 1'b1;
        redirect_pc0    = 16'h0101;
        @(negedge clk);
        n_checks++;
        if (mem_rd_en0 !== 1'b0) $display("FAIL redir_rd_en: got %b expected 0", mem_rd_en0);
        else n_pass++;
        @(posedge clk);
        #1 redirect_valid0 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_rd_en0, mem_addr0, instr_valid0} !== {1'b1, 16'h0100, 1'b0})
            $display("FAIL redir_first_req: got en=%b addr=%h v=%b expected en=1 addr=0100 v=0",
                     mem_rd_en0, mem_addr0, instr_valid0);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({mem_rd_en0, mem_addr0, instr_valid0} !== {1'b1, 16'h0101, 1'b0})
            $display("FAIL redir_lo_req: got en=%b addr=%h v=%b expected en=1 addr=0101 v=0",
                     mem_rd_en0, mem_addr0, instr_valid0);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (instr_valid0 !== 1'b0) $display("FAIL redir_no_stale: got %b expected 0", instr_valid0);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({instr_valid0, instr_word0, instr_pc0} !== {1'b1, 16'h5566, 16'h0100})
            $display("FAIL redir_word: got v=%b %h@%h expected v=1 5566@0100",
                     instr_valid0, instr_word0, instr_pc0);
        else n_pass++;
    endtask

    task automatic test_push_pop_full_minus1();
        start0(1'b0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 dec_ready0 = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({instr_valid0, instr_word0, mem_rd_en0} !== {1'b1, 16'h1234, 1'b0})
            $display("FAIL pp_c5: got v=%b word=%h en=%b expected v=1 word=1234 en=0",
                     instr_valid0, instr_word0, mem_rd_en0);
        else n_pass++;
        @(posedge clk);
        #1 dec_ready0 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({instr_valid0, instr_word0, instr_pc0} !== {1'b1, 16'h5678, 16'h0002})
            $display("FAIL pp_head: got v=%b %h@%h expected v=1 5678@0002",
                     instr_valid0, instr_word0, instr_pc0);
        else n_pass++;
        n_checks++;
        if ({mem_rd_en0, mem_addr0} !== {1'b1, 16'h0004})
            $display("FAIL pp_req: got en=%b addr=%h expected en=1 addr=0004", mem_rd_en0, mem_addr0);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (mem_rd_en0 !== 1'b0) $display("FAIL pp_stall: got %b expected 0", mem_rd_en0);
        else n_pass++;
        @(negedge clk);
        dec_ready0 = 1'b1;
        @(negedge clk);
        dec_ready0 = 1'b0;
        n_checks++;
        if ({instr_valid0, instr_word0, instr_pc0} !== {1'b1, 16'h9ABC, 16'h0004})
            $display("FAIL pp_order: got v=%b %h@%h expected v=1 9abc@0004",
                     instr_valid0, instr_word0, instr_pc0);
        else n_pass++;
        n_checks++;
        if ({mem_rd_en0, mem_addr0} !== {1'b1, 16'h0006})
            $display("FAIL pp_resume: got en=%b addr=%h expected en=1 addr=0006", mem_rd_en0, mem_addr0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        start0(1'b1);
        repeat (3) @(posedge clk);
        #1 reset0 = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({mem_rd_en0, instr_valid0} !== 2'b00)
            $display("FAIL rmid_outputs: got en=%b v=%b expected en=0 v=0", mem_rd_en0, instr_valid0);
        else n_pass++;
        @(posedge clk);
        #1 reset0 = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 1) begin
                n_checks++;
                if ({mem_rd_en0, mem_addr0} !== {1'b1, 16'h0000})
                    $display("FAIL rmid_restart: got en=%b addr=%h expected en=1 addr=0000",
                             mem_rd_en0, mem_addr0);
                else n_pass++;
            end
            if (n < 4) begin
                n_checks++;
                if (instr_valid0 !== 1'b0)
                    $display("FAIL rmid_no_stale c%0d: got %b expected 0", n, instr_valid0);
                else n_pass++;
            end else begin
                n_checks++;
                if ({instr_valid0, instr_word0, instr_pc0} !== {1'b1, 16'h1234, 16'h0000})
                    $display("FAIL rmid_word: got v=%b %h@%h expected v=1 1234@0000",
                             instr_valid0, instr_word0, instr_pc0);
                else n_pass++;
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] words [3] = '{16'hA1B2, 16'h1234, 16'h5678};
        logic [15:0] pcs   [3] = '{16'hFFFE, 16'h0000, 16'h0002};
        logic [15:0] exp_addr;
        logic        exp_v;
        int          idx;
        dec_ready1 = 1'b1;
        @(posedge clk);
        #1 reset1 = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            exp_addr = 16'hFFFE + 16'(n - 1);
            n_checks++;
            if ({mem_rd_en1, mem_addr1} !== {1'b1, exp_addr})
                $display("FAIL wrap_req c%0d: got en=%b addr=%h expected en=1 addr=%h",
                         n, mem_rd_en1, mem_addr1, exp_addr);
            else n_pass++;
            exp_v = (n >= 4) && (n % 2 == 0);
            n_checks++;
            if (instr_valid1 !== exp_v)
                $display("FAIL wrap_valid c%0d: got %b expected %b", n, instr_valid1, exp_v);
            else n_pass++;
            if (exp_v) begin
                idx = (n - 4) / 2;
                n_checks++;
                if ({instr_word1, instr_pc1} !== {words[idx], pcs[idx]})
                    $display("FAIL wrap_word c%0d: got %h@%h expected %h@%h",
                             n, instr_word1, instr_pc1, words[idx], pcs[idx]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'h0000] = 8'h12; mem[16'h0001] = 8'h34;
        mem[16'h0002] = 8'h56; mem[16'h0003] = 8'h78;
        mem[16'h0004] = 8'h9A; mem[16'h0005] = 8'hBC;
        mem[16'h0006] = 8'hDE; mem[16'h0007] = 8'hF0;
        mem[16'h0100] = 8'h55; mem[16'h0101] = 8'h66;
        mem[16'hFFFE] = 8'hA1; mem[16'hFFFF] = 8'hB2;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_push_pop_full_minus1();
        test_reset_mid();
        test_wrap();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch stage of the Small Practice CPU, directly upstream of `instr_decoder`. It reads 16-bit instruction words byte-by-byte from the byte-wide synchronous instruction memory and buffers them in a small FIFO. It presents each word with its PC to the decoder over a valid/ready handshake. A redirect input (branch/jump from the execute stage) flushes everything in flight and restarts fetch at a new PC.

## Interface
- `ADDR_W`, 16: byte address / PC width.
- `RESET_PC`, 16'h0000: PC fetched first after reset; bit 0 must be 0.
- `BUF_DEPTH`, 2: instruction buffer entries; power of two, ≥ 2.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `mem_rd_en` out 1: byte read request this cycle.
- `mem_addr` out ADDR_W: byte address of the request.
- `mem_rdata` in 8: read data, valid exactly one cycle after `mem_rd_en`.
- `instr_valid` out 1: buffer head holds a valid instruction.
- `instr_word` out 16: buffer head instruction, `{hi_byte, lo_byte}` (big-endian).
- `instr_pc` out ADDR_W: byte address of the head instruction's high byte.
- `dec_ready` in 1: the decoder accepts the head this cycle.
- `redirect_valid` in 1: flush and restart fetch.
- `redirect_pc` in ADDR_W: new PC; bit 0 is ignored and forced to 0.

## Operation
- Memory is big-endian. Each instruction is the byte at `pc` (high) followed by the byte at `pc+1` (low).
- The FSM has two states:
  - `S_HI`: issue the high-byte request at `fetch_pc`, but only when `buf_count + inflight < BUF_DEPTH`. `inflight` is 1 while an instruction has had a byte requested but has not yet been pushed. After issuing, go to `S_LO`; otherwise stay in `S_HI` with `mem_rd_en=0`.
  - `S_LO`: unconditionally issue the request at `fetch_pc+1`, then go to `S_HI` with `fetch_pc += 2`.
- Returned bytes are tracked by registered flags `pend_hi` and `pend_lo`, which mirror the previous cycle's request.
  - `pend_hi`: capture `mem_rdata` into `hi_byte`.
  - `pend_lo`: push `{hi_byte, mem_rdata}` with PC `fetch_pc-2` into the FIFO.
- Pop occurs when `instr_valid && dec_ready`. Push and pop in the same cycle are allowed; the count is unchanged.
- The space check makes push-when-full impossible. An assertion must flag it if it ever happens.
- Redirect has the highest priority.
  - The cycle `redirect_valid=1` is sampled: `mem_rd_en=0`, any pop is ignored, and no push occurs.
  - At that edge: FIFO count becomes 0, `pend_hi`/`pend_lo` clear (late data is discarded), state becomes `S_HI`, and `fetch_pc = {redirect_pc[ADDR_W-1:1],1'b0}`.
- Address arithmetic is modulo 2^ADDR_W. The instruction at 16'hFFFE is followed by the one at 16'h0000.
- Reset values: state `S_HI`, `fetch_pc=RESET_PC`, FIFO empty, flags clear, `mem_rd_en=0`, `instr_valid=0`. `mem_addr`, `instr_word` and `instr_pc` are don't-care while their qualifiers are low.
- Reset mid-operation aborts any request. Data returned in the following cycle is ignored.

## Timing
- `mem_rd_en` and `mem_addr` are combinational from the state, `fetch_pc` and the FIFO count.
- `instr_valid`, `instr_word` and `instr_pc` come from FIFO registers, with no combinational path from `dec_ready`.
- Latency after reset release or after a redirect sampled at edge E0:
  - hi request in the cycle after E0;
  - lo request in the next cycle;
  - push at the edge after the lo data returns;
  - `instr_valid=1` in the 4th cycle after E0.
- Throughput is one instruction per 2 cycles with `dec_ready` held high. Memory is never idle in steady state.
- Backpressure:
  - When the FIFO is full, fetch stalls in `S_HI` with no requests.
  - Fetch resumes in the cycle after the pop that makes space.
  - The lo request is never stalled.

## Structure
- Shared package `pkg_instr_fetch` holds:
  - the `fetch_state_t` enum (`S_HI`, `S_LO`);
  - the constants `INSTR_W=16` and `MEM_DATA_W=8`;
  - the packed struct `fetch_entry_t {word, pc}`, which is consumed by `instr_decoder`'s package.
- Sub-module `instr_fetch_fifo`: a synchronous FIFO of `fetch_entry_t` with push, pop, a flush input, count, and an empty output.

## Test plan
- Reset then release, memory bytes 0x00..0x07 = 12 34 56 78 9A BC DE F0, `dec_ready=1`:
  - words 0x1234, 0x5678, 0x9ABC, 0xDEF0 at PCs 0, 2, 4, 6;
  - first `instr_valid` on the 4th cycle after release;
  - one word every 2 cycles after that.
- `dec_ready=0` from reset: exactly BUF_DEPTH words buffered, then `mem_rd_en` stays 0. When `dec_ready` is raised for one cycle, one word pops and fetch resumes the next cycle at PC 4.
- Redirect to 0x0101 in the cycle a lo byte is returning:
  - that byte is not pushed and the FIFO empties;
  - next request is at address 0x0100;
  - first new `instr_pc` is 0x0100.
- `RESET_PC=16'hFFFE`: `instr_pc` sequence 0xFFFE, 0x0000, 0x0002; `mem_addr` wraps correctly.
- Simultaneous `dec_ready` pop and push with the FIFO full-1: count is unchanged and order is preserved.
- Assert `reset` while in `S_LO`: all outputs return to reset values. Fetch restarts at `RESET_PC` with no stale word delivered.
